// File: rtl/gb_mbc_multi.sv
// Cartridge mapper emulating ROM-only, MBC1 and MBC5 behaviour, mode latched during reset.
// Define MBC_RUMBLE_EN to add the MBC5 rumble output (bank2[3]) and narrow the MBC5 RAM bank.
module gb_mbc_multi #(
    parameter int ROM_ADR_W = 21,
    parameter int RAM_BANKS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 read,
    input  logic                 write,
    input  logic [7:0]           data,
    input  logic [15:0]          iadr,
    input  logic [1:0]           mode,
    output logic [ROM_ADR_W-1:0] oadr,
    output logic                 sel_rom,
    output logic                 sel_ram
`ifdef MBC_RUMBLE_EN
    ,
    output logic                 rumble
`endif
);

    localparam logic [1:0] MODE_MBC1 = 2'd1;
    localparam logic [1:0] MODE_MBC5 = 2'd2;

    // Banks wrap to the populated RAM size; 0 or 1 bank leaves no bank bits at all.
    localparam logic [3:0] RAM_MASK = (RAM_BANKS > 1) ? 4'(RAM_BANKS - 1) : 4'd0;
    localparam logic       HAS_RAM  = (RAM_BANKS != 0);

    logic [1:0] mode_q;
    logic       ram_en;
    logic [8:0] rom_bank;
    logic [3:0] bank2;
    logic       mbc1_mode;

    logic       is_mbc1;
    logic       is_mbc5;
    logic       rom_only;
    logic       reg_wr;
    logic       in_ram_win;
    logic [3:0] ram_bank_raw;
    logic [3:0] ram_bank;

    assign is_mbc1    = (mode_q == MODE_MBC1);
    assign is_mbc5    = (mode_q == MODE_MBC5);
    assign rom_only   = !is_mbc1 && !is_mbc5;
    assign reg_wr     = write && !iadr[15];
    assign in_ram_win = (iadr[15:13] == 3'b101);

    // Register file; a held write strobe simply rewrites the same value.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q    <= mode;
            ram_en    <= 1'b0;
            rom_bank  <= 9'd1;
            bank2     <= 4'd0;
            mbc1_mode <= 1'b0;
        end else if (reg_wr) begin
            if (is_mbc1) begin
                case (iadr[14:13])
                    2'b00: ram_en <= (data[3:0] == 4'hA);
                    2'b01: rom_bank[4:0] <= (data[4:0] == 5'd0) ? 5'd1 : data[4:0];
                    2'b10: bank2[1:0] <= data[1:0];
                    default: mbc1_mode <= data[0];
                endcase
            end else if (is_mbc5) begin
                case (iadr[14:12])
                    3'b000, 3'b001: ram_en <= (data == 8'h0A);
                    3'b010:         rom_bank[7:0] <= data;
                    3'b011:         rom_bank[8] <= data[0];
                    3'b100, 3'b101: bank2 <= data[3:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        ram_bank_raw = bank2;
        if (is_mbc1) begin
            ram_bank_raw = mbc1_mode ? {2'b00, bank2[1:0]} : 4'd0;
        end
`ifdef MBC_RUMBLE_EN
        else if (is_mbc5) begin
            ram_bank_raw = {1'b0, bank2[2:0]};
        end
`endif
        ram_bank = ram_bank_raw & RAM_MASK;
    end

    // Casts to ROM_ADR_W drop any bank bits that do not fit.
    always_comb begin
        oadr = ROM_ADR_W'(iadr[13:0]);
        case (iadr[15:13])
            3'b000, 3'b001: begin
                if (is_mbc1 && mbc1_mode) begin
                    oadr = ROM_ADR_W'({bank2[1:0], 5'd0, iadr[13:0]});
                end
            end
            3'b010, 3'b011: begin
                if (is_mbc1) begin
                    oadr = ROM_ADR_W'({bank2[1:0], rom_bank[4:0], iadr[13:0]});
                end else if (is_mbc5) begin
                    oadr = ROM_ADR_W'({rom_bank, iadr[13:0]});
                end else begin
                    oadr = ROM_ADR_W'(iadr[14:0]);
                end
            end
            3'b101: oadr = ROM_ADR_W'({ram_bank, iadr[12:0]});
            default: ;
        endcase
    end

    assign sel_rom = !reset && read && !iadr[15];
    assign sel_ram = !reset && (read || write) && in_ram_win && HAS_RAM && (ram_en || rom_only);

`ifdef MBC_RUMBLE_EN
    assign rumble = is_mbc5 && bank2[3];
`endif

endmodule
